// File: rtl/instr_fetch_queue_if.sv
// Fetch-side bus bundle: instruction memory request/response, redirect input
// and the decode-facing head-of-queue outputs.
interface instr_fetch_queue_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [5:0]  opcode;
    logic [5:0]  func;

    modport master (
        output imem_req, imem_addr, id_valid, id_instr, id_pc, opcode, func,
        input  imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, id_ready
    );

    modport slave (
        input  imem_req, imem_addr, id_valid, id_instr, id_pc, opcode, func,
        output imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, id_ready
    );

endinterface

// File: rtl/instr_fetch_queue.sv
// Instruction fetch unit: one outstanding memory request, a 2-entry
// instruction queue toward decode, and redirect with stale-response discard.
module instr_fetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    instr_fetch_queue_if.master bus
);

    localparam int               CNT_W    = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        WAIT    = 2'd2,
        DISCARD = 2'd3
    } state_t;

    state_t           state_r;
    state_t           state_nx_s;
    logic [31:0]      pc_r;
    logic [31:0]      pc_nx_s;
    logic [31:0]      fetch_pc_r;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_nx_s;
    logic [31:0]      q0_instr_r;
    logic [31:0]      q0_pc_r;
    logic [31:0]      q1_instr_r;
    logic [31:0]      q1_pc_r;
    logic [31:0]      q0_instr_nx_s;
    logic [31:0]      q0_pc_nx_s;
    logic [31:0]      q1_instr_nx_s;
    logic [31:0]      q1_pc_nx_s;
    logic             imem_req_r;
    logic             imem_req_nx_s;
    logic             id_valid_r;
    logic             accept_s;
    logic             push_s;
    logic             flush_s;
    logic             pop_s;

    function automatic logic [31:0] pc_step(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // FSM next-state decode
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                state_nx_s = REQ;
            end
            REQ: begin
                // A granted request with a same-cycle redirect still owes a response
                if (bus.redirect) begin
                    state_nx_s = accept_s ? DISCARD : REQ;
                end else if (accept_s) begin
                    state_nx_s = WAIT;
                end else begin
                    state_nx_s = REQ;
                end
            end
            WAIT: begin
                if (bus.imem_rvalid) begin
                    state_nx_s = REQ;
                end else if (bus.redirect) begin
                    state_nx_s = DISCARD;
                end else begin
                    state_nx_s = WAIT;
                end
            end
            DISCARD: begin
                if (bus.imem_rvalid) begin
                    state_nx_s = REQ;
                end else begin
                    state_nx_s = DISCARD;
                end
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // FSM output decode: handshake qualifiers per state
    always_comb begin
        accept_s = 1'b0;
        push_s   = 1'b0;
        flush_s  = 1'b0;
        case (state_r)
            IDLE: begin
                accept_s = 1'b0;
                push_s   = 1'b0;
                flush_s  = 1'b0;
            end
            REQ: begin
                accept_s = imem_req_r & bus.imem_gnt;
                flush_s  = bus.redirect;
            end
            WAIT: begin
                push_s  = bus.imem_rvalid & ~bus.redirect;
                flush_s = bus.redirect;
            end
            DISCARD: begin
                flush_s = bus.redirect;
            end
            default: begin
                accept_s = 1'b0;
                push_s   = 1'b0;
                flush_s  = 1'b0;
            end
        endcase
    end

    // Fetch PC and decode pop qualification
    always_comb begin
        pop_s = id_valid_r & bus.id_ready & ~flush_s;
        if (flush_s) begin
            pc_nx_s = bus.redirect_pc;
        end else if (accept_s) begin
            pc_nx_s = pc_step(pc_r);
        end else begin
            pc_nx_s = pc_r;
        end
    end

    // Queue update: the head always lives in slot 0 and vacant slots read as zero
    always_comb begin
        q0_instr_nx_s = q0_instr_r;
        q0_pc_nx_s    = q0_pc_r;
        q1_instr_nx_s = q1_instr_r;
        q1_pc_nx_s    = q1_pc_r;
        count_nx_s    = count_r;
        if (flush_s) begin
            q0_instr_nx_s = 32'h0;
            q0_pc_nx_s    = 32'h0;
            q1_instr_nx_s = 32'h0;
            q1_pc_nx_s    = 32'h0;
            count_nx_s    = CNT_ZERO;
        end else if (push_s && pop_s) begin
            if (count_r == CNT_ONE) begin
                q0_instr_nx_s = bus.imem_rdata;
                q0_pc_nx_s    = fetch_pc_r;
            end else begin
                q0_instr_nx_s = q1_instr_r;
                q0_pc_nx_s    = q1_pc_r;
                q1_instr_nx_s = bus.imem_rdata;
                q1_pc_nx_s    = fetch_pc_r;
            end
        end else if (push_s) begin
            if (count_r == CNT_ZERO) begin
                q0_instr_nx_s = bus.imem_rdata;
                q0_pc_nx_s    = fetch_pc_r;
                count_nx_s    = CNT_ONE;
            end else if (count_r == CNT_ONE) begin
                q1_instr_nx_s = bus.imem_rdata;
                q1_pc_nx_s    = fetch_pc_r;
                count_nx_s    = CNT_FULL;
            end else begin
                count_nx_s = count_r;
            end
        end else if (pop_s) begin
            q0_instr_nx_s = q1_instr_r;
            q0_pc_nx_s    = q1_pc_r;
            q1_instr_nx_s = 32'h0;
            q1_pc_nx_s    = 32'h0;
            count_nx_s    = count_r - CNT_ONE;
        end else begin
            count_nx_s = count_r;
        end
        imem_req_nx_s = (state_nx_s == REQ) && (count_nx_s < CNT_FULL);
    end

    // Datapath registers; the request strobe is precomputed from next state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_r       <= RESET_PC;
            fetch_pc_r <= 32'h0;
            count_r    <= CNT_ZERO;
            q0_instr_r <= 32'h0;
            q0_pc_r    <= 32'h0;
            q1_instr_r <= 32'h0;
            q1_pc_r    <= 32'h0;
            imem_req_r <= 1'b0;
            id_valid_r <= 1'b0;
        end else begin
            pc_r <= pc_nx_s;
            if (accept_s) begin
                fetch_pc_r <= pc_r;
            end
            count_r    <= count_nx_s;
            q0_instr_r <= q0_instr_nx_s;
            q0_pc_r    <= q0_pc_nx_s;
            q1_instr_r <= q1_instr_nx_s;
            q1_pc_r    <= q1_pc_nx_s;
            imem_req_r <= imem_req_nx_s;
            id_valid_r <= (count_nx_s != CNT_ZERO);
        end
    end

    assign bus.imem_req  = imem_req_r;
    assign bus.imem_addr = pc_r;
    assign bus.id_valid  = id_valid_r;
    assign bus.id_instr  = q0_instr_r;
    assign bus.id_pc     = q0_pc_r;
    assign bus.opcode    = q0_instr_r[31:26];
    assign bus.func      = q0_instr_r[5:0];

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a transaction-level model.
module tb_instr_fetch_queue;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    instr_fetch_queue_if ifq();

    instr_fetch_queue #(.RESET_PC(RESET_PC), .DEPTH(2)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (ifq)
    );

    int total = 0;
    int bad   = 0;

    // memory responder
    bit          mem_pending = 1'b0;
    int          mem_cnt     = 0;
    int          mem_lat     = 1;
    logic [31:0] mem_addr    = 32'h0;
    bit          spur_en     = 1'b0;
    bit          rand_lat    = 1'b0;

    // reference model: program counter, queue contents, outstanding request
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;
    ent_t        mq[$];
    logic [31:0] m_pc    = RESET_PC;
    logic [31:0] m_opc   = 32'h0;
    bit          m_out   = 1'b0;
    bit          m_stale = 1'b0;
    bit          m_start = 1'b1;
    bit          m_known = 1'b0;

    function automatic logic [31:0] word(input logic [31:0] a);
        return a ^ 32'hDEAD_BEEF;
    endfunction

    function automatic bit m_req();
        return !m_start && !m_out && (mq.size() < 2);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit acc;
        bit arrive;
        acc    = m_req() && ifq.imem_gnt;
        arrive = m_out && ifq.imem_rvalid;
        if (!rst_n) begin
            m_pc    = RESET_PC;
            mq.delete();
            m_out   = 1'b0;
            m_stale = 1'b0;
            m_start = 1'b1;
            m_known = 1'b1;
        end else if (m_start) begin
            m_start = 1'b0;
        end else if (ifq.redirect) begin
            mq.delete();
            m_pc    = ifq.redirect_pc;
            m_out   = (m_out && !ifq.imem_rvalid) || acc;
            m_stale = m_out;
        end else begin
            if (mq.size() > 0 && ifq.id_ready) void'(mq.pop_front());
            if (arrive) begin
                if (!m_stale) mq.push_back('{instr: ifq.imem_rdata, pc: m_opc});
                m_out   = 1'b0;
                m_stale = 1'b0;
            end
            if (acc) begin
                m_out   = 1'b1;
                m_stale = 1'b0;
                m_opc   = m_pc;
                m_pc    = m_pc + 32'd4;
            end
        end
    endtask

    task automatic compare_outputs();
        logic [31:0] ei;
        logic [31:0] ep;
        if (!m_known) return;
        ei = (mq.size() > 0) ? mq[0].instr : 32'h0;
        ep = (mq.size() > 0) ? mq[0].pc : 32'h0;
        chk("imem_req", 32'(ifq.imem_req), 32'(m_req()));
        if (m_req()) chk("imem_addr", ifq.imem_addr, m_pc);
        chk("id_valid", 32'(ifq.id_valid), 32'(mq.size() > 0));
        chk("id_instr", ifq.id_instr, ei);
        chk("id_pc", ifq.id_pc, ep);
        chk("opcode", 32'(ifq.opcode), 32'(ei[31:26]));
        chk("func", 32'(ifq.func), 32'(ei[5:0]));
    endtask

    // one clock: memory drives response, edge, model update, compare at negedge
    task automatic tick();
        bit          fire;
        logic        dut_req;
        logic [31:0] dut_addr;
        fire = mem_pending && (mem_cnt == 0);
        if (fire) begin
            ifq.imem_rvalid = 1'b1;
            ifq.imem_rdata  = word(mem_addr);
        end else if (spur_en && !mem_pending && ($urandom_range(0, 4) == 0)) begin
            ifq.imem_rvalid = 1'b1;
            ifq.imem_rdata  = $urandom;
        end else begin
            ifq.imem_rvalid = 1'b0;
            ifq.imem_rdata  = 32'h0;
        end
        dut_req  = ifq.imem_req;
        dut_addr = ifq.imem_addr;
        @(posedge clk);
        model_step();
        if (fire) mem_pending = 1'b0;
        else if (mem_pending) mem_cnt--;
        if (dut_req && ifq.imem_gnt) begin
            if (rand_lat) mem_lat = int'($urandom_range(1, 3));
            mem_pending = 1'b1;
            mem_cnt     = mem_lat - 1;
            mem_addr    = dut_addr;
        end
        @(negedge clk);
        compare_outputs();
    endtask

    task automatic do_reset();
        rst_n           = 1'b0;
        ifq.redirect    = 1'b0;
        ifq.redirect_pc = 32'h0;
        ifq.imem_gnt    = 1'b0;
        ifq.id_ready    = 1'b0;
        mem_pending     = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n           = 1'b0;
        ifq.imem_gnt    = 1'b0;
        ifq.imem_rvalid = 1'b0;
        ifq.imem_rdata  = 32'h0;
        ifq.redirect    = 1'b0;
        ifq.redirect_pc = 32'h0;
        ifq.id_ready    = 1'b0;
        @(negedge clk);

        // streaming fetch, one-cycle memory
        do_reset();
        chk("rst_req", 32'(ifq.imem_req), 32'h0);
        chk("rst_valid", 32'(ifq.id_valid), 32'h0);
        chk("rst_instr", ifq.id_instr, 32'h0);
        chk("rst_pc", ifq.id_pc, 32'h0);
        ifq.imem_gnt = 1'b1; ifq.id_ready = 1'b1; mem_lat = 1;
        tick();
        chk("s_req0", 32'(ifq.imem_req), 32'h1);
        chk("s_addr0", ifq.imem_addr, 32'h0);
        tick();
        chk("s_wait_req", 32'(ifq.imem_req), 32'h0);
        tick();
        chk("s_valid1", 32'(ifq.id_valid), 32'h1);
        chk("s_idpc0", ifq.id_pc, 32'h0);
        chk("s_instr0", ifq.id_instr, 32'hDEAD_BEEF);
        chk("s_opcode0", 32'(ifq.opcode), 32'h37);
        chk("s_addr4", ifq.imem_addr, 32'h4);
        tick(); tick();
        chk("s_idpc4", ifq.id_pc, 32'h4);
        chk("s_addr8", ifq.imem_addr, 32'h8);

        // decode stall fills the queue
        do_reset();
        ifq.imem_gnt = 1'b1; ifq.id_ready = 1'b0; mem_lat = 1;
        repeat (5) tick();
        chk("f_valid", 32'(ifq.id_valid), 32'h1);
        chk("f_head", ifq.id_pc, 32'h0);
        chk("f_req_off", 32'(ifq.imem_req), 32'h0);
        tick(); tick();
        chk("f_req_still", 32'(ifq.imem_req), 32'h0);
        ifq.id_ready = 1'b1;
        tick();
        chk("f_pop_pc", ifq.id_pc, 32'h4);
        chk("f_pop_instr", ifq.id_instr, word(32'h4));
        chk("f_resume_req", 32'(ifq.imem_req), 32'h1);
        chk("f_resume_addr", ifq.imem_addr, 32'h8);
        tick(); tick();
        chk("f_pc8", ifq.id_pc, 32'h8);

        // redirect while waiting, two-cycle memory
        do_reset();
        ifq.imem_gnt = 1'b1; ifq.id_ready = 1'b1; mem_lat = 2;
        tick(); tick();
        ifq.redirect = 1'b1; ifq.redirect_pc = 32'h0000_0100;
        tick();
        ifq.redirect = 1'b0;
        chk("d_req", 32'(ifq.imem_req), 32'h0);
        tick();
        chk("d_req_new", 32'(ifq.imem_req), 32'h1);
        chk("d_addr_new", ifq.imem_addr, 32'h100);
        chk("d_valid0", 32'(ifq.id_valid), 32'h0);
        tick();
        chk("d_valid1", 32'(ifq.id_valid), 32'h0);
        tick();
        chk("d_valid2", 32'(ifq.id_valid), 32'h0);
        tick();
        chk("d_valid3", 32'(ifq.id_valid), 32'h1);
        chk("d_pc", ifq.id_pc, 32'h100);

        // redirect coincident with response, one entry queued
        do_reset();
        ifq.imem_gnt = 1'b1; ifq.id_ready = 1'b0; mem_lat = 1;
        repeat (4) tick();
        ifq.redirect = 1'b1; ifq.redirect_pc = 32'h0000_0200;
        tick();
        chk("r_valid", 32'(ifq.id_valid), 32'h0);
        chk("r_instr", ifq.id_instr, 32'h0);
        chk("r_opcode", 32'(ifq.opcode), 32'h0);
        chk("r_func", 32'(ifq.func), 32'h0);
        chk("r_addr", ifq.imem_addr, 32'h200);
        ifq.redirect = 1'b0; ifq.id_ready = 1'b1;
        tick(); tick();
        chk("r_pc", ifq.id_pc, 32'h200);
        chk("r_instr2", ifq.id_instr, word(32'h200));

        // address wrap
        do_reset();
        ifq.imem_gnt = 1'b0; ifq.id_ready = 1'b1; mem_lat = 1;
        tick();
        ifq.redirect = 1'b1; ifq.redirect_pc = 32'hFFFF_FFFC;
        tick();
        ifq.redirect = 1'b0;
        chk("w_addr", ifq.imem_addr, 32'hFFFF_FFFC);
        ifq.imem_gnt = 1'b1;
        tick(); tick();
        chk("w_idpc", ifq.id_pc, 32'hFFFF_FFFC);
        chk("w_next", ifq.imem_addr, 32'h0);

        // reset mid-wait, response lands in IDLE
        do_reset();
        ifq.imem_gnt = 1'b1; ifq.id_ready = 1'b1; mem_lat = 2;
        tick(); tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("x_req_idle", 32'(ifq.imem_req), 32'h0);
        tick();
        chk("x_valid", 32'(ifq.id_valid), 32'h0);
        chk("x_addr", ifq.imem_addr, RESET_PC);
        ifq.imem_gnt = 1'b0;
        tick();
        chk("x_valid2", 32'(ifq.id_valid), 32'h0);

        // randomized traffic
        spur_en = 1'b1; rand_lat = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            rst_n        = ($urandom_range(0, 199) != 0);
            ifq.imem_gnt = ($urandom_range(0, 9) < 7);
            ifq.id_ready = ($urandom_range(0, 9) < 6);
            ifq.redirect = ($urandom_range(0, 15) == 0);
            case ($urandom_range(0, 3))
                0:       ifq.redirect_pc = $urandom;
                1:       ifq.redirect_pc = 32'hFFFF_FFF8;
                default: ifq.redirect_pc = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
            endcase
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_fetch_queue.md
INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 The block SHALL have parameter DEPTH, default 2, meaning the instruction queue entry count; only the value 2 is supported.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-005 The block SHALL have port imem_req, output, 1 bit: fetch request valid.
REQ-006 The block SHALL have port imem_addr, output, 32 bits: fetch byte address.
REQ-007 The block SHALL have port imem_gnt, input, 1 bit: memory accepts the request this cycle.
REQ-008 The block SHALL have port imem_rvalid, input, 1 bit: read data valid.
REQ-009 The block SHALL have port imem_rdata, input, 32 bits: instruction word.
REQ-010 The block SHALL have port redirect, input, 1 bit: a jump or branch was taken.
REQ-011 The block SHALL have port redirect_pc, input, 32 bits: the new fetch address.
REQ-012 The block SHALL have port id_ready, input, 1 bit: decode accepts the head entry (deasserted on stall).
REQ-013 The block SHALL have port id_valid, output, 1 bit: the queue is non-empty.
REQ-014 The block SHALL have port id_instr, output, 32 bits: the head instruction.
REQ-015 The block SHALL have port id_pc, output, 32 bits: the head instruction address.
REQ-016 The block SHALL have port opcode, output, 6 bits: id_instr[31:26], to the control decoder.
REQ-017 The block SHALL have port func, output, 6 bits: id_instr[5:0], to the control decoder.

Function
REQ-018 The FSM SHALL have the states IDLE, REQ, WAIT and DISCARD; IDLE SHALL be entered only from reset and SHALL exit to REQ after 1 cycle.
REQ-019 In REQ, imem_req SHALL be 1 only when count<2, and imem_addr SHALL equal pc.
REQ-020 A request SHALL complete when imem_req and imem_gnt are both 1: the block SHALL latch pc as fetch_pc, set pc<=pc+4 (modulo 2^32, wrapping at 32'hFFFF_FFFC to 0) and go to WAIT.
REQ-021 At most one request SHALL be outstanding, and imem_req SHALL be 0 in IDLE, WAIT and DISCARD.
REQ-022 In WAIT with imem_rvalid=1 and redirect=0, the block SHALL push {imem_rdata, fetch_pc} into the queue and go to REQ.
REQ-023 The queue SHALL be a 2-entry FIFO with count 0..2; id_instr, id_pc and id_valid SHALL come from the head entry; a pop SHALL occur when id_valid and id_ready are both 1.
REQ-024 On a simultaneous push and pop, count SHALL be unchanged and order SHALL be preserved; a push cannot occur at count=2 because a request issues only at count<=1.
REQ-025 When the queue is empty, id_valid SHALL be 0 and id_instr SHALL be 32'h0 (NOP), so opcode=0 and func=0.
REQ-026 On redirect=1 in any non-IDLE state, the block SHALL flush the queue (count<=0, no pop counted), set pc<=redirect_pc, and drop any same-cycle imem_rvalid data.
REQ-027 After a redirect, the next state SHALL be DISCARD if a request remains outstanding: either in WAIT with rvalid=0, or in REQ with a same-cycle gnt, whose stale address was sent. Otherwise the next state SHALL be REQ.
REQ-028 In DISCARD, the block SHALL wait for imem_rvalid, drop the data and go to REQ; a further redirect in DISCARD SHALL update pc only.
REQ-029 imem_rvalid SHALL be ignored in IDLE and REQ.
REQ-030 A redirect_pc that is not word-aligned SHALL be used as-is; the low 2 bits are not checked.

Reset
REQ-031 When rst_n=0 at a clock edge, the block SHALL set state=IDLE, pc=RESET_PC, count=0, imem_req=0, id_valid=0, id_instr=0, id_pc=0; reset SHALL take priority over redirect and all handshakes.
REQ-032 On reset mid-transaction, the block SHALL abandon any outstanding request; an rvalid arriving in IDLE SHALL be ignored.

Verification
REQ-033 Release reset; gnt=1 always; rvalid one cycle after gnt; id_ready=1 -> imem_addr sequence 0,4,8; id_pc follows 0,4,8; first id_valid 3 cycles after reset release.
REQ-034 Hold id_ready=0 -> queue fills with the words at 0 and 4, imem_req stays 0, and count=2; raise id_ready -> words pop in order, then fetch resumes at 8.
REQ-035 Redirect to 32'h0000_0100 while in WAIT with 2-cycle rvalid latency -> late data dropped (DISCARD), next imem_addr=0x100, and id_valid stays 0 until the 0x100 word returns.
REQ-036 Redirect in the same cycle as rvalid with count=1 -> queue empty next cycle and the rvalid word never appears at id_instr.
REQ-037 pc=32'hFFFF_FFFC fetch granted -> next imem_addr=0.
REQ-038 Assert rst_n=0 during WAIT, then pulse rvalid during IDLE -> no push, id_valid=0, and first imem_addr after reset is RESET_PC.
